// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states, default operand width and small op-decode helpers.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unit: shift-add multiply step or restoring divide step
// on unsigned magnitudes. Purely combinational.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_rem,
  input  logic [WIDTH-1:0]   i_opb,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0]   o_rem
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  // MUL: acc = {hi, remaining multiplier bits}; add multiplicand into hi on lsb, then shift right.
  assign w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opb} : '0);

  // DIV: acc low half shifts dividend bits out of its msb and quotient bits into its lsb.
  // The restored remainder is always below the divisor, so a WIDTH-bit difference suffices.
  assign w_shift = {i_rem, i_acc[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, i_opb});
  assign w_diff  = w_shift[WIDTH-1:0] - i_opb;

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    o_acc = i_acc;
    o_rem = i_rem;
    if (i_is_div) begin
      o_rem = w_ge ? w_diff : w_shift[WIDTH-1:0];
      o_acc = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-2:0], w_ge};
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply/divide, one bit per cycle, for the EX stage.
// Optional MULDIV_EARLY_OUT_EN: zero-operand MUL and divide-by-zero finish on the accept edge.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic               stallreq_o,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dbz;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_opb;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_busy;

  op_e                w_op;
  logic               w_is_div;
  logic               w_s1;
  logic               w_s2;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [2*WIDTH-1:0] w_step_acc;
  logic [WIDTH-1:0]   w_step_rem;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_remf;
  logic [2*WIDTH-1:0] w_result;

  assign w_op     = op_e'(op_i);
  assign w_is_div = op_is_div(w_op);
  assign w_s1     = op_is_signed(w_op) & opdata1_i[WIDTH-1];
  assign w_s2     = op_is_signed(w_op) & opdata2_i[WIDTH-1];
  assign w_mag1   = w_s1 ? -opdata1_i : opdata1_i;
  assign w_mag2   = w_s2 ? -opdata2_i : opdata2_i;

`ifdef MULDIV_EARLY_OUT_EN
  logic               w_early;
  logic [2*WIDTH-1:0] w_early_res;

  assign w_early     = w_is_div ? (opdata2_i == '0) : ((opdata1_i == '0) || (opdata2_i == '0));
  assign w_early_res = w_is_div ? {opdata1_i, {WIDTH{1'b1}}} : '0;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_rem    (r_rem),
    .i_opb    (r_opb),
    .o_acc    (w_step_acc),
    .o_rem    (w_step_rem)
  );

  // With a zero divisor the restoring loop leaves |dividend| in the remainder,
  // so re-applying the dividend sign returns opdata1_i unchanged.
  assign w_prod   = r_neg_q ? -r_acc : r_acc;
  assign w_quo    = r_dbz ? {WIDTH{1'b1}} : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_remf   = r_neg_r ? -r_rem : r_rem;
  assign w_result = r_is_div ? {w_remf, w_quo} : w_prod;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: every datapath flop is reset too, so nothing from an aborted op leaks out.
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b0;
          if (start_i && !annul_i) begin
            r_is_div <= w_is_div;
            r_neg_q  <= w_s1 ^ w_s2;
            r_neg_r  <= w_s1;
            r_dbz    <= w_is_div && (opdata2_i == '0);
            r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
            r_opb    <= w_is_div ? w_mag2 : w_mag1;
            r_rem    <= '0;
            r_cnt    <= '0;
`ifdef MULDIV_EARLY_OUT_EN
            if (w_early) begin
              r_result <= w_early_res;
              r_ready  <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= ST_BUSY;
            end
`else
            r_busy  <= 1'b1;
            r_state <= ST_BUSY;
`endif
          end
        end
        ST_BUSY: begin
          if (annul_i) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_cnt == CNT_W'(WIDTH)) begin
            r_result <= w_result;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_DONE;
          end else begin
            r_acc <= w_step_acc;
            r_rem <= w_step_rem;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Gated by resetn so that every output reads 0 while reset is held.
  assign stallreq_o = resetn & (((r_state == ST_IDLE) & start_i) | (r_state == ST_BUSY));
  assign busy_o     = r_busy;
  assign ready_o    = r_ready;
  assign result_o   = r_result;

endmodule
